rf_write_arbiter: RTL and testbench

Round-robin write-port arbiter and initializer for the 16 x 16-bit register file (`regfile`). It shares the register file's single write port (`wn`, `d`, `we`) between `NREQ` requesters, such as ALU lanes, the load unit and the host. After every reset it first clears all 16 registers. Its outputs connect directly to `regfile` write inputs.

---
 rtl/rf_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: clears all 2^AW registers after reset, then arbitrates NREQ requesters onto the regfile write port.
// Latency: gnt is combinational from req; an accepted write drives we/wn/d in the next cycle.
// Backpressure: a requester holds req/req_wn/req_d until gnt; gnt stays 0 during reset and the clear sequence.
// Build option RF_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_wn,
  input  logic [NREQ*DW-1:0]   req_d,
  output logic [NREQ-1:0]      gnt,
  output logic                 init_done,
  output logic [AW-1:0]        wn,
  output logic [DW-1:0]        d,
  output logic                 we
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  // One extra bit: the cycle with cnt == 2^AW issues no write and hands over to RUN,
  // so init_done and the first possible grant coincide one cycle after the last clear write.
  logic [AW:0]     cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wn_q, wn_d;
  logic [DW-1:0]   d_q, d_d;
  logic            init_done_q, init_done_d;

  logic [PW-1:0]   ptr_cur;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] gnt_c;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign ptr_cur = '0;
`else
  logic [PW-1:0]   ptr_q, ptr_d;
  assign ptr_cur = ptr_q;
`endif

  // Search req from ptr_cur upward, wrapping modulo NREQ; first set bit wins.
  always_comb begin
    gnt_c = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (reset_n && (state_q == RUN)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PW'((int'(ptr_cur) + k) % NREQ);
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found) begin
        gnt_c[win] = 1'b1;
      end
    end
  end

  assign gnt = gnt_c;

  // Next-state and next-output computation for the INIT/RUN controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    wn_d        = wn_q;
    d_d         = d_q;
    init_done_d = init_done_q;
`ifndef RF_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      INIT: begin
        if (!cnt_q[AW]) begin
          we_d  = 1'b1;
          wn_d  = cnt_q[AW-1:0];
          d_d   = '0;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (found) begin
          we_d = 1'b1;
          wn_d = req_wn[win*AW +: AW];
          d_d  = req_d[win*DW +: DW];
`ifndef RF_ARB_FIXED_PRIO_EN
          if (win == PW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and registered outputs; reset drops whatever write was computed this cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wn_q        <= '0;
      d_q         <= '0;
      init_done_q <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wn_q        <= wn_d;
      d_q         <= d_d;
      init_done_q <= init_done_d;
`ifndef RF_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign we        = we_q;
  assign wn        = wn_q;
  assign d         = d_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter (NREQ=4, DW=16, AW=4) with a downstream regfile model.
// Expected writes are queued when a grant is checked and compared when we/wn/d appear.
// Also honours RF_ARB_FIXED_PRIO_EN for the fairness expectations.
module tb_rf_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_wn;
  logic [63:0] req_d;
  logic [3:0]  gnt;
  logic        init_done;
  logic [3:0]  wn;
  logic [15:0] d;
  logic        we;

  typedef struct packed {
    logic [3:0]  wn;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] rf [16];
  int          checks;
  int          errors;

  rf_write_arbiter #(.NREQ(4), .DW(16), .AW(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_wn    (req_wn),
    .req_d     (req_d),
    .gnt       (gnt),
    .init_done (init_done),
    .wn        (wn),
    .d         (d),
    .we        (we)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Downstream register file: captures the write port at the rising edge.
  always @(posedge clock) begin
    if (we === 1'b1) rf[wn] <= d;
  end

  // Scoreboard consumer: every RUN-phase write must match the oldest expected write.
  always @(negedge clock) begin
    #3;
    if (init_done === 1'b1 && we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got wn=%0d d=%h, no write expected", wn, d);
      end else begin
        mon_e = sb.pop_front();
        if (wn !== mon_e.wn || d !== mon_e.d) begin
          errors++;
          $display("FAIL sb_write: got wn=%0d d=%h, expected wn=%0d d=%h", wn, d, mon_e.wn, mon_e.d);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [3:0] w, input logic [15:0] v);
    req_wn[i*4 +: 4]  = w;
    req_d[i*16 +: 16] = v;
  endtask

  task automatic test_reset(input logic [3:0] rq);
    @(negedge clock);
    reset_n = 1'b0;
    req     = rq;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: gnt=%b, expected 0000", gnt);
    end
    @(negedge clock);
    #1;
    checks++;
    if (we !== 1'b0 || wn !== 4'd0 || d !== 16'h0000 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b wn=%0d d=%h init_done=%b, expected 0 0 0000 0", we, wn, d, init_done);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_clear();
    for (int r = 0; r < 16; r++) rf[r] = 16'hDEAD;
    test_reset(4'b0000);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (we !== 1'b1 || wn !== 4'(k - 1) || d !== 16'h0000 || init_done !== 1'b0 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL clear_cycle%0d: we=%b wn=%0d d=%h init_done=%b gnt=%b, expected 1 %0d 0000 0 0000",
                 k, we, wn, d, init_done, gnt, k - 1);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (init_done !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: init_done=%b we=%b on cycle 17, expected 1 0", init_done, we);
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (rf[r] !== 16'h0000) begin
        errors++;
        $display("FAIL clear_reg%0d: reads %h, expected 0000", r, rf[r]);
      end
    end
  endtask

  task automatic test_init_req();
    set_req(0, 4'd3, 16'h0123);
    test_reset(4'b0001);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (k < 17) begin
        if (gnt !== 4'b0000 || init_done !== 1'b0) begin
          errors++;
          $display("FAIL init_req_hold%0d: gnt=%b init_done=%b, expected 0000 0", k, gnt, init_done);
        end
      end else begin
        if (gnt !== 4'b0001 || init_done !== 1'b1) begin
          errors++;
          $display("FAIL init_req_first: gnt=%b init_done=%b, expected 0001 1", gnt, init_done);
        end
        sb.push_back(exp_t'({4'd3, 16'h0123}));
      end
    end
    @(negedge clock);
    req = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL init_req_once: gnt=%b after drop, expected 0000", gnt);
    end
  endtask

  task automatic test_single_write();
    @(negedge clock);
    set_req(2, 4'd5, 16'h1001);
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt: gnt=%b, expected 0100", gnt);
    end
    sb.push_back(exp_t'({4'd5, 16'h1001}));
    @(negedge clock);
    req = 4'b0000;
    #1;
    checks++;
    if (we !== 1'b1 || wn !== 4'd5 || d !== 16'h1001) begin
      errors++;
      $display("FAIL single_port: we=%b wn=%0d d=%h, expected 1 5 1001", we, wn, d);
    end
    @(negedge clock);
    #1;
    checks++;
    if (rf[5] !== 16'h1001) begin
      errors++;
      $display("FAIL single_readback: reg5=%h, expected 1001", rf[5]);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg;
    int         e;
    // A lone grant to requester 3 brings the round-robin pointer back to 0.
    @(negedge clock);
    set_req(3, 4'd3, 16'hF003);
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL fair_pre: gnt=%b, expected 1000", gnt);
    end
    sb.push_back(exp_t'({4'd3, 16'hF003}));
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 16'hF000 + 16'(i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      req = 4'b1111;
      #1;
`ifdef RF_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 4;
`endif
      eg = 4'b0001 << e;
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL fair_grant%0d: gnt=%b, expected %b", k, gnt, eg);
      end
      sb.push_back(exp_t'({4'(e), 16'hF000 + 16'(e)}));
    end
    @(negedge clock);
    req = 4'b0000;
  endtask

  task automatic test_collision();
    @(negedge clock);
    set_req(1, 4'd7, 16'hAAAA);
    set_req(3, 4'd7, 16'hBBBB);
    req = 4'b1010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL coll_first: gnt=%b, expected 0010", gnt);
    end
    sb.push_back(exp_t'({4'd7, 16'hAAAA}));
    @(negedge clock);
    req = 4'b1000;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL coll_second: gnt=%b, expected 1000", gnt);
    end
    sb.push_back(exp_t'({4'd7, 16'hBBBB}));
    @(negedge clock);
    req = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL coll_idle: gnt=%b, expected 0000", gnt);
    end
    @(negedge clock);
    #1;
    checks++;
    if (rf[7] !== 16'hBBBB) begin
      errors++;
      $display("FAIL coll_final: reg7=%h, expected BBBB", rf[7]);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 8), 16'h5500 + 16'(i));
    @(negedge clock);
    req = 4'b1111;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_pre: gnt=%b, expected 0001", gnt);
    end
    sb.push_back(exp_t'({4'd8, 16'h5500}));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_gnt: gnt=%b while reset low, expected 0000", gnt);
    end
    @(negedge clock);
    #1;
    checks++;
    if (we !== 1'b0 || wn !== 4'd0 || d !== 16'h0000 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_out: we=%b wn=%0d d=%h init_done=%b, expected 0 0 0000 0", we, wn, d, init_done);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (k < 17) begin
        if (we !== 1'b1 || wn !== 4'(k - 1) || gnt !== 4'b0000) begin
          errors++;
          $display("FAIL mid_clear%0d: we=%b wn=%0d gnt=%b, expected 1 %0d 0000", k, we, wn, gnt, k - 1);
        end
      end else begin
        if (init_done !== 1'b1 || gnt !== 4'b0001) begin
          errors++;
          $display("FAIL mid_ptr0: init_done=%b gnt=%b, expected 1 0001", init_done, gnt);
        end
        sb.push_back(exp_t'({4'd8, 16'h5500}));
      end
    end
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    req     = 4'b0000;
    req_wn  = '0;
    req_d   = '0;
    test_clear();
    test_init_req();
    test_single_write();
    test_fairness();
    test_collision();
    test_mid_reset();
    @(negedge clock);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected writes never seen, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
